// File: rtl/min_uint32_serial.sv
// Bit-serial unsigned minimum of two WIDTH-bit operands, MSB first, with valid/ready handshakes.
// Define MIN_UINT32_SERIAL_EARLY_EXIT_EN to leave CMP as soon as the first differing bit decides.
module min_uint32_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             sel
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] TOP_BIT = CW'(WIDTH - 1);

`ifdef MIN_UINT32_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             sel_acc;

    logic a_bit;
    logic b_bit;
    logic diff_now;
    logic sel_now;
    logic cmp_last;

    assign a_bit = a_reg[cnt];
    assign b_bit = b_reg[cnt];

    // Only the first differing bit pair may set the decision; sel_now folds in this cycle's bit.
    always_comb begin
        diff_now = 1'b0;
        sel_now  = sel_acc;
        cmp_last = 1'b0;
        diff_now = !decided && (a_bit != b_bit);
        if (diff_now) begin
            sel_now = ~b_bit;
        end
        cmp_last = (cnt == '0) || (EARLY_EXIT && diff_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                if (cmp_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Y and sel only change when CMP finishes, so they keep the previous result meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            sel_acc <= 1'b0;
            Y       <= '0;
            sel     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        cnt     <= TOP_BIT;
                        decided <= 1'b0;
                        sel_acc <= 1'b0;
                    end
                end
                CMP: begin
                    if (diff_now) begin
                        decided <= 1'b1;
                        sel_acc <= ~b_bit;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (cmp_last) begin
                        sel <= sel_now;
                        Y   <= sel_now ? b_reg : a_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_uint32_serial.sv
// Self-checking bench for min_uint32_serial: directed cases from the requirements plus random pairs,
// checked against an arithmetic reference (min, B<A, latency from the highest differing bit).
module tb_min_uint32_serial;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         sel;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] last_y;
    logic         last_sel;

    min_uint32_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Edges counted from the accept edge (inclusive) until out_valid is seen.
    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        int cmp_cycles;
        cmp_cycles = W;
`ifdef MIN_UINT32_SERIAL_EARLY_EXIT_EN
        begin
            logic [W-1:0] d;
            d = a ^ b;
            for (int i = 0; i < W; i++) begin
                if (d[i]) cmp_cycles = W - i;
            end
        end
`endif
        return cmp_cycles + 1;
    endfunction

    // Called at a negedge while idle; returns at a negedge just after the output handshake.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] ey;
        logic         es;
        int           lat;
        ey  = (b < a) ? b : a;
        es  = (b < a);
        check_output("in_ready_idle", 64'(in_ready), 64'(1));
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        lat       = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            A        = $urandom;
            B        = $urandom;
            if (!out_valid) begin
                check_output("y_retained", 64'(Y), 64'(last_y));
                check_output("sel_retained", 64'(sel), 64'(last_sel));
                check_output("in_ready_busy", 64'(in_ready), 64'(0));
            end
        end while (!out_valid && lat < 200);
        check_output("latency", 64'(lat), 64'(exp_latency(a, b)));
        check_output("y", 64'(Y), 64'(ey));
        check_output("sel", 64'(sel), 64'(es));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A        = $urandom;
            B        = $urandom;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check_output("hold_valid", 64'(out_valid), 64'(1));
            check_output("hold_y", 64'(Y), 64'(ey));
            check_output("hold_sel", 64'(sel), 64'(es));
            check_output("hold_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("post_out_valid", 64'(out_valid), 64'(0));
        check_output("post_in_ready", 64'(in_ready), 64'(1));
        check_output("post_y", 64'(Y), 64'(ey));
        last_y   = ey;
        last_sel = es;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        last_y    = '0;
        last_sel  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_in_ready", 64'(in_ready), 64'(1));
        check_output("rst_out_valid", 64'(out_valid), 64'(0));
        check_output("rst_y", 64'(Y), 64'(0));
        check_output("rst_sel", 64'(sel), 64'(0));

        apply_stimulus(32'h0000_0005, 32'h0000_0003, 0);
        apply_stimulus(32'h8000_0000, 32'h7FFF_FFFF, 0);
        apply_stimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        apply_stimulus(32'h1234_5678, 32'h1234_5670, 10);
        apply_stimulus(32'h0000_0000, 32'hFFFF_FFFF, 0);
        apply_stimulus(32'hFFFF_FFFF, 32'h0000_0000, 0);

        // Abort mid-compare: the captured pair must never produce a result.
        A        = 32'hFFFF_FFFF;
        B        = 32'h0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_in_ready", 64'(in_ready), 64'(1));
        check_output("abort_out_valid", 64'(out_valid), 64'(0));
        check_output("abort_y", 64'(Y), 64'(0));
        check_output("abort_sel", 64'(sel), 64'(0));
        last_y   = '0;
        last_sel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("abort_no_result", 64'(out_valid), 64'(0));
        end
        apply_stimulus(32'h0000_0001, 32'h0000_0002, 0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case (n % 4)
                0: rb = ra;
                1: rb = ra ^ (32'h1 << $urandom_range(0, W - 1));
                2: rb = ra ^ 32'(1 << $urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            apply_stimulus(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
